// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: BHT branch prediction in IF, resolution/flush/PC-select in EX, with saturating stats
module branch_predict_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int CTR_W       = 2,
  parameter int STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              if_pred_taken,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_pred_taken,
  input  logic              zero,
  input  logic              negative,
  input  logic              overflow,
  input  logic              jump,
  input  logic              branchbeq,
  input  logic              branchbne,
  input  logic              branchblez,
  input  logic              branchbgtz,
  output logic [1:0]        out,
  output logic              flush,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CTR_W-1:0] ctr_init = CTR_W'((1 << (CTR_W - 1)) - 1);
  logic [CTR_W-1:0] bht [BHT_ENTRIES];
  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [CTR_W-1:0] ex_ctr;
  logic is_br, taken, upd, mis;
  logic unused_pc;
  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_ctr = bht[ex_idx];
  assign unused_pc = ^{if_pc[ADDR_W-1:IDX_W+2], if_pc[1:0], ex_pc[ADDR_W-1:IDX_W+2], ex_pc[1:0]};
  assign if_pred_taken = bht[if_idx][CTR_W-1];
  assign is_br = branchbeq | branchbne | branchblez | branchbgtz;
  assign taken = (branchbeq & zero & ~negative & ~overflow) | (branchbne & ~zero) |
                 (branchblez & (zero | negative)) | (branchbgtz & ~zero & ~negative);
  assign upd = is_br & ~jump;
  assign mis = upd & (taken ^ ex_pred_taken);
  assign out = jump ? 2'd2 : mis ? (taken ? 2'd1 : 2'd3) : 2'd0;
  assign flush = jump | mis;
  // train the resolved branch's counter toward its actual direction, saturating at both ends
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= ctr_init;
    else if (upd)
      bht[ex_idx] <= taken ? (&ex_ctr ? ex_ctr : ex_ctr + CTR_W'(1))
                           : (|ex_ctr ? ex_ctr - CTR_W'(1) : ex_ctr);
  // count resolved branches and mispredicts, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (upd) begin
      if (~&stat_branches) stat_branches <= stat_branches + STAT_W'(1);
      if (mis && ~&stat_mispred) stat_mispred <= stat_mispred + STAT_W'(1);
    end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb_branch_predict_ctrl: directed and randomized checks against a behavioural predictor model
module tb_branch_predict_ctrl;
  logic clk = 0, rst_n = 0;
  logic [31:0] if_pc = 0, ex_pc = 0;
  logic ex_pred_taken = 0, zero = 0, negative = 0, overflow = 0, jump = 0;
  logic beq = 0, bne = 0, blez = 0, bgtz = 0;
  logic pred, flush, s_pred, s_flush;
  logic [1:0] out, s_out;
  logic [15:0] sb, sm;
  logic [3:0] s_sb, s_sm;
  int checks = 0, errors = 0;
  int mctr[16];
  int nbr = 0, nmis = 0;

  always #5 clk = ~clk;

  branch_predict_ctrl dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(pred), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .zero(zero), .negative(negative), .overflow(overflow),
    .jump(jump), .branchbeq(beq), .branchbne(bne), .branchblez(blez), .branchbgtz(bgtz),
    .out(out), .flush(flush), .stat_branches(sb), .stat_mispred(sm)
  );

  branch_predict_ctrl #(.STAT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(s_pred), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .zero(zero), .negative(negative), .overflow(overflow),
    .jump(jump), .branchbeq(beq), .branchbne(bne), .branchblez(blez), .branchbgtz(bgtz),
    .out(s_out), .flush(s_flush), .stat_branches(s_sb), .stat_mispred(s_sm)
  );

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic bit m_isbr();
    return beq || bne || blez || bgtz;
  endfunction

  function automatic bit m_taken();
    bit t = 0;
    if (beq && zero && !negative && !overflow) t = 1;
    if (bne && !zero) t = 1;
    if (blez && (zero || negative)) t = 1;
    if (bgtz && !zero && !negative) t = 1;
    return t;
  endfunction

  function automatic logic [1:0] m_out();
    if (jump) return 2'd2;
    if (m_isbr() && m_taken() && !ex_pred_taken) return 2'd1;
    if (m_isbr() && !m_taken() && ex_pred_taken) return 2'd3;
    return 2'd0;
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return mctr[idx(pc)] >= 2;
  endfunction

  function automatic int sat(input int n, input int m);
    return n > m ? m : n;
  endfunction

  task automatic clear_in();
    jump = 0; beq = 0; bne = 0; blez = 0; bgtz = 0;
    zero = 0; negative = 0; overflow = 0; ex_pred_taken = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mctr[i] = 1;
    nbr = 0;
    nmis = 0;
  endtask

  task automatic tick();
    int i;
    @(posedge clk);
    if (rst_n && m_isbr() && !jump) begin
      i = idx(ex_pc);
      if (m_taken()) begin
        if (mctr[i] < 3) mctr[i]++;
      end else if (mctr[i] > 0) mctr[i]--;
      nbr++;
      if (m_taken() != ex_pred_taken) nmis++;
    end
    #1;
  endtask

  task automatic test_reset();
    clear_in();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      if_pc = 32'(i * 4);
      #1;
      checks++;
      if (pred !== 1'b0) begin errors++; $display("FAIL reset_pred if_pc=%h got %b exp 0", if_pc, pred); end
    end
    checks++;
    if (sb !== 16'd0 || sm !== 16'd0) begin errors++; $display("FAIL reset_stats got %0d/%0d exp 0/0", sb, sm); end
    checks++;
    if (out !== 2'd0 || flush !== 1'b0) begin errors++; $display("FAIL reset_out got %0d/%b exp 0/0", out, flush); end
  endtask

  task automatic test_beq_mispredict();
    @(negedge clk);
    ex_pc = 32'h40; beq = 1; zero = 1; ex_pred_taken = 0;
    #1;
    checks++;
    if (out !== 2'd1 || flush !== 1'b1) begin errors++; $display("FAIL beq_mis got out=%0d flush=%b exp 1/1", out, flush); end
    tick();
    clear_in();
    if_pc = 32'h40;
    #1;
    checks++;
    if (pred !== 1'b1) begin errors++; $display("FAIL beq_train got %b exp 1", pred); end
    checks++;
    if (sb !== 16'd1 || sm !== 16'd1) begin errors++; $display("FAIL beq_stats got %0d/%0d exp 1/1", sb, sm); end
  endtask

  task automatic test_bne_saturate();
    @(negedge clk);
    ex_pc = 32'h44; bne = 1; zero = 1; ex_pred_taken = 1;
    #1;
    checks++;
    if (out !== 2'd3 || flush !== 1'b1) begin errors++; $display("FAIL bne_mis got out=%0d flush=%b exp 3/1", out, flush); end
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ex_pred_taken = m_pred(ex_pc);
      #1;
      checks++;
      if (out !== m_out() || flush !== 1'b0) begin errors++; $display("FAIL bne_ok got out=%0d flush=%b exp %0d/0", out, flush, m_out()); end
      tick();
      if_pc = 32'h44;
      #1;
      checks++;
      if (pred !== 1'b0) begin errors++; $display("FAIL bne_underflow iter=%0d got %b exp 0", k, pred); end
    end
    clear_in();
  endtask

  task automatic test_jump();
    int b0;
    b0 = nbr;
    @(negedge clk);
    ex_pc = 32'h50; if_pc = 32'h50; jump = 1; beq = 1; zero = 1; ex_pred_taken = 0;
    #1;
    checks++;
    if (out !== 2'd2 || flush !== 1'b1) begin errors++; $display("FAIL jump got out=%0d flush=%b exp 2/1", out, flush); end
    tick();
    clear_in();
    #1;
    checks++;
    if (pred !== 1'b0) begin errors++; $display("FAIL jump_no_update got %b exp 0", pred); end
    checks++;
    if (int'(sb) !== b0 || int'(sm) !== nmis) begin errors++; $display("FAIL jump_stats got %0d/%0d exp %0d/%0d", sb, sm, b0, nmis); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    if_pc = 32'h48; ex_pc = 32'h48; bgtz = 1; zero = 0; negative = 0; ex_pred_taken = 0;
    #1;
    checks++;
    if (pred !== 1'b0) begin errors++; $display("FAIL same_cycle_pre got %b exp 0", pred); end
    tick();
    checks++;
    if (pred !== 1'b1) begin errors++; $display("FAIL same_cycle_post got %b exp 1", pred); end
    clear_in();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      jump = ($urandom % 8) == 0;
      beq = ($urandom % 3) == 0;
      bne = ($urandom % 4) == 0;
      blez = ($urandom % 4) == 0;
      bgtz = ($urandom % 4) == 0;
      zero = $urandom % 2; negative = $urandom % 2; overflow = ($urandom % 4) == 0;
      ex_pc = $urandom;
      if_pc = $urandom;
      ex_pred_taken = ($urandom % 4) != 0 ? m_pred(ex_pc) : 1'($urandom % 2);
      #1;
      checks++;
      if (out !== m_out()) begin errors++; $display("FAIL rand_out n=%0d got %0d exp %0d", n, out, m_out()); end
      checks++;
      if (flush !== (m_out() != 2'd0)) begin errors++; $display("FAIL rand_flush n=%0d got %b exp %b", n, flush, m_out() != 2'd0); end
      checks++;
      if (pred !== m_pred(if_pc)) begin errors++; $display("FAIL rand_pred n=%0d if_pc=%h got %b exp %b", n, if_pc, pred, m_pred(if_pc)); end
      checks++;
      if (int'(sb) !== sat(nbr, 65535) || int'(sm) !== sat(nmis, 65535)) begin errors++; $display("FAIL rand_stats n=%0d got %0d/%0d exp %0d/%0d", n, sb, sm, nbr, nmis); end
      checks++;
      if (int'(s_sb) !== sat(nbr, 15) || int'(s_sm) !== sat(nmis, 15)) begin errors++; $display("FAIL rand_small_stats n=%0d got %0d/%0d exp %0d/%0d", n, s_sb, s_sm, sat(nbr, 15), sat(nmis, 15)); end
      tick();
    end
    clear_in();
  endtask

  task automatic test_stat_saturate();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      ex_pc = 32'h4C; beq = 1; zero = 1; ex_pred_taken = 0;
      #1;
      checks++;
      if (out !== 2'd1 || s_out !== 2'd1) begin errors++; $display("FAIL sat_out n=%0d got %0d/%0d exp 1/1", n, out, s_out); end
      tick();
    end
    checks++;
    if (s_sm !== 4'd15 || s_sb !== 4'd15) begin errors++; $display("FAIL sat_small got %0d/%0d exp 15/15", s_sb, s_sm); end
    checks++;
    if (int'(sm) !== sat(nmis, 65535) || int'(sb) !== sat(nbr, 65535)) begin errors++; $display("FAIL sat_big got %0d/%0d exp %0d/%0d", sb, sm, nbr, nmis); end
  endtask

  task automatic test_async_reset();
    if_pc = 32'h4C;
    ex_pc = 32'h4C; beq = 1; zero = 1; ex_pred_taken = 0;
    #1;
    checks++;
    if (pred !== 1'b1) begin errors++; $display("FAIL pre_reset_pred got %b exp 1", pred); end
    rst_n = 0;
    #1;
    checks++;
    if (pred !== 1'b0 || s_pred !== 1'b0) begin errors++; $display("FAIL async_pred got %b/%b exp 0/0", pred, s_pred); end
    checks++;
    if (sb !== 16'd0 || sm !== 16'd0 || s_sb !== 4'd0 || s_sm !== 4'd0) begin errors++; $display("FAIL async_stats got %0d/%0d/%0d/%0d exp 0", sb, sm, s_sb, s_sm); end
    model_reset();
    for (int i = 0; i < 16; i++) begin
      if_pc = 32'(i * 4);
      #1;
      checks++;
      if (pred !== 1'b0) begin errors++; $display("FAIL async_sweep if_pc=%h got %b exp 0", if_pc, pred); end
    end
    @(negedge clk);
    clear_in();
    rst_n = 1;
    if_pc = 32'h4C;
    #1;
    checks++;
    if (pred !== 1'b0 || sb !== 16'd0) begin errors++; $display("FAIL post_reset got pred=%b sb=%0d exp 0/0", pred, sb); end
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_bne_saturate();
    test_jump();
    test_same_cycle();
    test_random();
    test_stat_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
